hv_bind_bundle_encoder: RTL and testbench

- Sits directly downstream of the CA90 item memory.
- Streams pairs of item indices. Drives them combinationally into the item memory's two select ports and XOR-binds the two returned hypervectors.
- Accumulates the bound vectors in per-bit saturating counters. On the last item of a frame it majority-thresholds them into one bundled hypervector.
- The result is handed off through a valid/ready output handshake to the associative-memory or training stage.

---
 rtl/hv_bind_bundle_encoder_pkg.sv | 19 +
 rtl/hv_bind_bundle_encoder_if.sv | 33 +++
 rtl/hv_sat_counter.sv | 42 ++++
 rtl/hv_bind_bundle_encoder.sv | 123 ++++++++++++
 tb/tb_hv_bind_bundle_encoder.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/hv_bind_bundle_encoder_pkg.sv
// Shared types and constants for the hypervector bind/bundle encoder.
package hv_encoder_pkg;

  // Frame state: accumulating pairs, or holding a finished result.
  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } enc_state_e;

  // Default per-bit counter width and its saturation ceiling.
  localparam int unsigned   CounterWidthDefault = 8;
  localparam logic [7:0]    SatMax              = 8'hFF;

  // Saturation ceiling for an arbitrary counter width.
  function automatic int unsigned sat_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/hv_bind_bundle_encoder_if.sv
// Item stream, item-memory select/data and result handshake of the encoder.
interface hv_bind_bundle_encoder_if #(
  parameter int unsigned HVDimension  = 512,
  parameter int unsigned ImSelWidth   = 10,
  parameter int unsigned CounterWidth = 8
);
  logic [ImSelWidth-1:0]   item_a_i;
  logic [ImSelWidth-1:0]   item_b_i;
  logic                    item_last_i;
  logic                    item_valid_i;
  logic                    item_ready_o;
  logic [ImSelWidth-1:0]   im_sel_a_o;
  logic [ImSelWidth-1:0]   im_sel_b_o;
  logic [HVDimension-1:0]  im_a_i;
  logic [HVDimension-1:0]  im_b_i;
  logic [HVDimension-1:0]  hv_o;
  logic                    hv_valid_o;
  logic                    hv_ready_i;
  logic [CounterWidth-1:0] sample_cnt_o;
  logic                    sat_o;

  // Encoder side.
  modport slave (
    input  item_a_i, item_b_i, item_last_i, item_valid_i, im_a_i, im_b_i, hv_ready_i,
    output item_ready_o, im_sel_a_o, im_sel_b_o, hv_o, hv_valid_o, sample_cnt_o, sat_o
  );

  // Producer / item memory / consumer side.
  modport master (
    output item_a_i, item_b_i, item_last_i, item_valid_i, im_a_i, im_b_i, hv_ready_i,
    input  item_ready_o, im_sel_a_o, im_sel_b_o, hv_o, hv_valid_o, sample_cnt_o, sat_o
  );
endinterface

// File: rtl/hv_sat_counter.sv
// Saturating up-counter: holds at all-ones, flags increments lost at the ceiling.
module hv_sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [Width-1:0] cnt,
  output logic             hit
);
  localparam logic [Width-1:0] MaxVal = {Width{1'b1}};
  localparam logic [Width-1:0] One    = {{(Width-1){1'b0}}, 1'b1};

  logic [Width-1:0] cnt_next;

  // Next count: clear wins, otherwise increment unless already at the ceiling.
  always_comb begin
    cnt_next = cnt;
    hit      = 1'b0;
    if (clr) begin
      cnt_next = '0;
    end else if (en) begin
      if (cnt == MaxVal) begin
        hit = 1'b1;
      end else begin
        cnt_next = cnt + One;
      end
    end else begin
      cnt_next = cnt;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end
endmodule

// File: rtl/hv_bind_bundle_encoder.sv
// XOR-binds item-memory hypervector pairs and majority-bundles a frame of them.
module hv_bind_bundle_encoder
  import hv_encoder_pkg::*;
#(
  parameter int unsigned HVDimension  = 512,
  parameter int unsigned ImSelWidth   = 10,
  parameter int unsigned CounterWidth = CounterWidthDefault
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  hv_bind_bundle_encoder_if.slave    bus
);
  localparam int unsigned CW = CounterWidth;

  enc_state_e             state;
  enc_state_e             state_next;
  logic                   accept;
  logic                   handshake;
  logic                   frame_clr;
  logic                   sat_hit;
  logic [HVDimension-1:0] bound;
  logic [HVDimension-1:0] bit_hit;
  logic [HVDimension-1:0] thr;
  logic [HVDimension-1:0] hv_r;
  logic                   sat_r;
  logic [CW-1:0]          cnt_all [HVDimension];
  logic [CW-1:0]          samp;
  logic [CW-1:0]          samp_next;
  logic                   samp_hit;

  // The item memory is combinational: selects pass straight through.
  assign bus.im_sel_a_o = bus.item_a_i;
  assign bus.im_sel_b_o = bus.item_b_i;
  assign bound          = bus.im_a_i ^ bus.im_b_i;

  // clr_i overrides both the input accept and the output handshake.
  assign accept    = (state == ACCUM) & bus.item_valid_i & ~clr_i;
  assign handshake = (state == DONE) & bus.hv_ready_i & ~clr_i;
  assign frame_clr = clr_i | handshake;

  hv_sat_counter #(.Width(CW)) u_samp_cnt (
    .clk(clk_i), .rst_n(rst_ni), .clr(frame_clr), .en(accept),
    .cnt(samp), .hit(samp_hit)
  );

  // Threshold is only consumed on an accept, so the post-update sample
  // count is the current one plus one unless it is already saturated.
  assign samp_next = samp + {{(CW-1){1'b0}}, ~samp_hit};

  for (genvar k = 0; k < HVDimension; k++) begin : g_bit
    logic [CW-1:0] cnt_next_k;

    hv_sat_counter #(.Width(CW)) u_cnt (
      .clk(clk_i), .rst_n(rst_ni), .clr(frame_clr), .en(accept & bound[k]),
      .cnt(cnt_all[k]), .hit(bit_hit[k])
    );

    assign cnt_next_k = cnt_all[k] + {{(CW-1){1'b0}}, bound[k] & ~bit_hit[k]};
    // Strict majority in CW+1 bits; ties resolve to 0.
    assign thr[k] = ({cnt_next_k, 1'b0} > {1'b0, samp_next});
  end

  assign sat_hit = (|bit_hit) | samp_hit;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // Next state: finish a frame on the last accept, return on handshake or clear.
  always_comb begin
    state_next = state;
    if (clr_i) begin
      state_next = ACCUM;
    end else begin
      case (state)
        ACCUM: begin
          if (accept && bus.item_last_i) state_next = DONE;
          else                           state_next = ACCUM;
        end
        DONE: begin
          if (handshake) state_next = ACCUM;
          else           state_next = DONE;
        end
        default: state_next = ACCUM;
      endcase
    end
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    bus.item_ready_o = 1'b0;
    bus.hv_valid_o   = 1'b0;
    case (state)
      ACCUM:   bus.item_ready_o = 1'b1;
      DONE:    bus.hv_valid_o   = 1'b1;
      default: bus.item_ready_o = 1'b0;
    endcase
  end

  // Result vector and sticky saturation flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hv_r  <= '0;
      sat_r <= 1'b0;
    end else begin
      if (accept && bus.item_last_i) hv_r <= thr;
      else                           hv_r <= hv_r;
      if (frame_clr)                 sat_r <= 1'b0;
      else if (accept && sat_hit)    sat_r <= 1'b1;
      else                           sat_r <= sat_r;
    end
  end

  assign bus.hv_o         = hv_r;
  assign bus.sat_o        = sat_r;
  assign bus.sample_cnt_o = samp;
endmodule

// File: tb/tb_hv_bind_bundle_encoder.sv
// Scoreboard bench: random item memory, frame-level majority reference model.
module tb_hv_bind_bundle_encoder;
  localparam int unsigned HV   = 512;
  localparam int unsigned SEL  = 10;
  localparam int unsigned CW   = 4;
  localparam int          MAXC = (1 << CW) - 1;

  typedef struct packed {
    logic [HV-1:0] hv;
    logic [CW-1:0] samp;
    logic          sat;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic clr_i;

  logic [HV-1:0] im_mem [1024];
  logic [HV-1:0] fb [$];
  exp_t          sb [$];
  logic [HV-1:0] last_hv;
  int total = 0;
  int bad   = 0;

  hv_bind_bundle_encoder_if #(.HVDimension(HV), .ImSelWidth(SEL), .CounterWidth(CW)) bus ();

  assign bus.im_a_i = im_mem[bus.im_sel_a_o];
  assign bus.im_b_i = im_mem[bus.im_sel_b_o];

  hv_bind_bundle_encoder #(.HVDimension(HV), .ImSelWidth(SEL), .CounterWidth(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .bus(bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [HV-1:0] act, input logic [HV-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Majority of all bound vectors of the frame, counts clipped at MAXC.
  function automatic exp_t model_frame();
    exp_t e;
    int n = fb.size();
    int s = (n > MAXC) ? MAXC : n;
    e.sat = (n > MAXC);
    for (int k = 0; k < HV; k++) begin
      int c = 0;
      foreach (fb[i]) c += int'(fb[i][k]);
      if (c > MAXC) begin
        e.sat = 1'b1;
        c = MAXC;
      end
      e.hv[k] = (2 * c > s);
    end
    e.samp = CW'(s);
    return e;
  endfunction

  task automatic send_pair(input int a, input int b, input bit last);
    bit got = 0;
    bus.item_a_i     = SEL'(a);
    bus.item_b_i     = SEL'(b);
    bus.item_last_i  = last;
    bus.item_valid_i = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk_i);
      if (bus.item_ready_o) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL accept_timeout got=0 want=1");
    end
    @(posedge clk_i);
    #1;
    bus.item_valid_i = 1'b0;
    bus.item_last_i  = 1'b0;
    fb.push_back(im_mem[a] ^ im_mem[b]);
    if (last) begin
      exp_t e = model_frame();
      sb.push_back(e);
      last_hv = e.hv;
      fb.delete();
      chk("valid_latency", HV'(bus.hv_valid_o), HV'(1'b1));
    end
  endtask

  task automatic take_result(input int stall);
    for (int t = 0; t < stall; t++) begin
      @(posedge clk_i);
      #1;
    end
    bus.hv_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.hv_ready_i = 1'b0;
  endtask

  // Monitor: while a result is presented compare it to the scoreboard head
  // every cycle (also covers stability during stalls); pop on handshake.
  always @(negedge clk_i) begin
    if (rst_ni && bus.hv_valid_o) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result got=valid want=none");
      end else begin
        chk("hv", bus.hv_o, sb[0].hv);
        chk("sample_cnt", HV'(bus.sample_cnt_o), HV'(sb[0].samp));
        chk("sat", HV'(bus.sat_o), HV'(sb[0].sat));
        chk("ready_low_done", HV'(bus.item_ready_o), HV'(1'b0));
        if (bus.hv_ready_i && !clr_i) void'(sb.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++)
      for (int w = 0; w < HV / 32; w++) im_mem[i][w*32 +: 32] = $urandom;
    im_mem[101] = ~im_mem[100];

    rst_ni = 1'b0; clr_i = 1'b0;
    bus.item_a_i = '0; bus.item_b_i = '0; bus.item_last_i = 1'b0;
    bus.item_valid_i = 1'b0; bus.hv_ready_i = 1'b0;
    last_hv = '0;
    #12;
    chk("rst_hv", bus.hv_o, '0);
    chk("rst_valid", HV'(bus.hv_valid_o), '0);
    chk("rst_samp", HV'(bus.sample_cnt_o), '0);
    chk("rst_sat", HV'(bus.sat_o), '0);
    chk("rst_ready", HV'(bus.item_ready_o), HV'(1'b1));
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Identical indices bind to zero.
    send_pair(3, 3, 1'b1);
    take_result(1);

    // Three-pair majority with a 4-cycle consumer stall.
    send_pair(5, 0, 1'b0);
    send_pair(5, 0, 1'b0);
    send_pair(9, 0, 1'b1);
    take_result(4);

    // Complementary bound vectors: every bit ties.
    send_pair(100, 0, 1'b0);
    send_pair(101, 0, 1'b1);
    take_result(0);

    // Twenty identical pairs saturate the 4-bit counters.
    for (int i = 0; i < 20; i++) send_pair(7, 42, i == 19);
    take_result(2);

    // clr_i on the second pair drops it and aborts the frame.
    send_pair(11, 12, 1'b0);
    bus.item_a_i = SEL'(13); bus.item_b_i = SEL'(14);
    bus.item_valid_i = 1'b1; clr_i = 1'b1;
    @(posedge clk_i); #1;
    bus.item_valid_i = 1'b0; clr_i = 1'b0;
    fb.delete();
    chk("clr_samp", HV'(bus.sample_cnt_o), '0);
    chk("clr_valid", HV'(bus.hv_valid_o), '0);
    chk("clr_sat", HV'(bus.sat_o), '0);
    chk("clr_hv_kept", bus.hv_o, last_hv);
    send_pair(15, 16, 1'b1);
    take_result(1);

    // Random frames.
    for (int f = 0; f < 8; f++) begin
      int len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++)
        send_pair($urandom_range(0, 1023), $urandom_range(0, 1023), i == len - 1);
      take_result($urandom_range(0, 3));
    end

    // Asynchronous reset while a result is held.
    send_pair(20, 21, 1'b1);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    chk("rst_done_valid", HV'(bus.hv_valid_o), '0);
    chk("rst_done_hv", bus.hv_o, '0);
    void'(sb.pop_front());
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("rst_done_ready", HV'(bus.item_ready_o), HV'(1'b1));
    chk("rst_done_samp", HV'(bus.sample_cnt_o), '0);

    send_pair(30, 31, 1'b1);
    take_result(0);
    repeat (2) @(posedge clk_i);
    chk("scoreboard_empty", HV'(sb.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
